// File: rtl/aes_pkg.sv
// Shared AES types, key-length lookup, xtime and S-box table.
// Used by the key schedule and the round datapath.
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] rkey_t;

  typedef enum logic [1:0] {
    KL_128  = 2'b00,
    KL_192  = 2'b01,
    KL_256  = 2'b10,
    KL_RSVD = 2'b11
  } key_len_e;

  typedef enum logic {
    KS_IDLE,
    KS_EXPAND
  } ks_state_e;

  typedef struct packed {
    logic [3:0] nk;
    logic [3:0] nr;
  } ks_cfg_t;

  function automatic ks_cfg_t ks_cfg(input logic [1:0] kl);
    ks_cfg_t c;
    c = '0;
    case (key_len_e'(kl))
      KL_128:  c = '{nk: 4'd4, nr: 4'd10};
      KL_192:  c = '{nk: 4'd6, nr: 4'd12};
      KL_256:  c = '{nk: 4'd8, nr: 4'd14};
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte 0x00 sits in the top 8 bits.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b111} -: 8];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte.
// Shared between SubWord in the key schedule and SubBytes.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  assign out_o = sbox(in_i);

endmodule

// File: rtl/aes_key_sched_seq.sv
// Iterative AES-128/192/256 key expansion, one word per clock.
// Holds the full schedule and serves registered round-key reads.
module aes_key_sched_seq
  import aes_pkg::*;
#(
  parameter int MAX_NK = 8,
  parameter int MAX_NR = MAX_NK + 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         keys_valid,
  output logic         word_valid,
  output logic [5:0]   word_idx,
  output logic [31:0]  word_out,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_data
);

  localparam int DEPTH = 4 * (MAX_NR + 1);
  localparam logic [3:0] MAX_NK4 = 4'(MAX_NK);

  word_t     w_q [DEPTH];
  ks_state_e state_q;
  logic [3:0] nk_q, nr_q;
  logic [5:0] i_q;
  logic [7:0] rcon_q;
  logic [2:0] p_q;
  logic       loaded_q;
  logic       busy_q, done_q, err_q, kv_q, wv_q;
  logic [5:0] widx_q;
  word_t      wout_q;
  rkey_t      rk_q;

  ks_cfg_t cfg;
  logic    legal;
  word_t   prev_w, back_w, sub_in, sub_out, tmp_w, new_w;
  logic    last, p_wrap;
  logic [5:0] rk_base;
  rkey_t   rk_d;

  assign cfg    = ks_cfg(key_len);
  assign legal  = (key_len != KL_RSVD) && (cfg.nk <= MAX_NK4);
  assign prev_w = w_q[i_q - 6'd1];
  assign back_w = w_q[i_q - {2'b00, nk_q}];
  assign sub_in = (p_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
  assign last   = (i_q == {nr_q, 2'b11});
  assign p_wrap = ({1'b0, p_q} == nk_q - 4'd1);

  for (genvar b = 0; b < 4; b++) begin : g_sb
    aes_sbox u_sb (
      .in_i  (sub_in[8*b +: 8]),
      .out_o (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    tmp_w = prev_w;
    if (p_q == 3'd0)
      tmp_w = sub_out ^ {rcon_q, 24'h0};
    else if (nk_q == 4'd8 && p_q == 3'd4)
      tmp_w = sub_out;
    new_w = back_w ^ tmp_w;
  end

  always_comb begin
    rk_base = {rk_idx, 2'b00};
    rk_d    = '0;
    if (loaded_q && rk_idx <= nr_q)
      rk_d = {w_q[rk_base], w_q[rk_base + 6'd1],
              w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) w_q[k] <= '0;
      state_q  <= KS_IDLE;
      nk_q     <= '0;
      nr_q     <= '0;
      i_q      <= '0;
      rcon_q   <= '0;
      p_q      <= '0;
      loaded_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      kv_q     <= 1'b0;
      wv_q     <= 1'b0;
      widx_q   <= '0;
      wout_q   <= '0;
      rk_q     <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      wv_q   <= 1'b0;
      rk_q   <= rk_d;
      unique case (state_q)
        KS_IDLE: begin
          if (start && legal) begin
            for (int j = 0; j < MAX_NK; j++)
              if (4'(j) < cfg.nk) w_q[j] <= key[255-32*j -: 32];
            nk_q     <= cfg.nk;
            nr_q     <= cfg.nr;
            i_q      <= {2'b00, cfg.nk};
            rcon_q   <= 8'h01;
            p_q      <= '0;
            loaded_q <= 1'b1;
            busy_q   <= 1'b1;
            kv_q     <= 1'b0;
            state_q  <= KS_EXPAND;
          end else if (start) begin
            err_q <= 1'b1;
          end
        end
        KS_EXPAND: begin
          w_q[i_q] <= new_w;
          wv_q     <= 1'b1;
          widx_q   <= i_q;
          wout_q   <= new_w;
          if (p_q == 3'd0) rcon_q <= xtime(rcon_q);
          p_q <= p_wrap ? 3'd0 : p_q + 3'd1;
          i_q <= i_q + 6'd1;
          if (last) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            kv_q    <= 1'b1;
            state_q <= KS_IDLE;
          end
        end
        default: state_q <= KS_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign keys_valid = kv_q;
  assign word_valid = wv_q;
  assign word_idx   = widx_q;
  assign word_out   = wout_q;
  assign rk_data    = rk_q;

endmodule
